stream_mux_arb: RTL and testbench
=================================

// Module: stream_mux_arb
// PURPOSE
//  N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes and a
//  2-entry registered output buffer. Generalises the 4:1 32-bit combinational
//  mux to N channels, with two grant modes: externally selected or round-robin.
//  Used wherever several pipeline producers share one consumer, e.g. writeback
//  or memory request merging in the core. Output is fully registered, so no
//  combinational path runs from out_ready to in_ready.
// PARAMETERS
//  WIDTH     32              data width per channel
//  N         4               number of input channels, >=2
//  SEL_W     $clog2(N)       select/source index width (derived; do not override)
//  ARB_MODE  ARB_FIXED       ARB_FIXED: grant = sel; ARB_RR: round-robin arbitration
// PORTS
//  clk        in   1           clock, rising edge
//  rst        in   1           synchronous reset, active-high
//  in_valid   in   N           per-channel data valid
//  in_ready   out  N           per-channel accept; at most one bit set per cycle
//  in_data    in   N x WIDTH   per-channel data (unpacked array [N])
//  sel        in   SEL_W       channel select; used only in ARB_FIXED
//  out_valid  out  1           output buffer holds data
//  out_ready  in   1           consumer accepts the head entry
//  out_data   out  WIDTH       head entry data
//  out_src    out  SEL_W       channel index the head entry came from
// BEHAVIOUR
//  - Reset (rst=1 at posedge): count=0, out_valid=0, out_data=0, out_src=0,
//    rr_ptr=N-1 (first RR grant goes to ch0). Any in-flight data is dropped.
//  - space = (count<2), registered state only. in_ready[i] = space && (i==grant).
//  - Grant:
//    - ARB_FIXED: grant = sel. If sel>=N, no grant: all in_ready=0.
//      in_ready[sel] is asserted even when in_valid[sel]=0.
//    - ARB_RR: grant = first i with in_valid[i]=1, scanning from rr_ptr+1
//      modulo N. If no channel is valid, in_ready=0.
//  - Push: in_valid[grant] && in_ready[grant] writes {in_data[grant], grant}
//    into the buffer tail. In ARB_RR only, rr_ptr<=grant on a push; rr_ptr is
//    unchanged when there is no push, including when the buffer is full.
//  - Pop: out_valid && out_ready removes the head. The buffer is FIFO-ordered;
//    the 2nd entry becomes head on the cycle after a pop.
//  - Simultaneous push and pop: count is unchanged and order is preserved.
//    This is legal at count=1. At count=2 no push is possible.
//  - Latency: data pushed at edge k is visible on out_data with out_valid=1
//    after edge k (one cycle). Sustained throughput is 1 transfer/cycle when
//    out_ready=1.
//  - While out_valid=1 and out_ready=0, out_data and out_src stay stable.
//  - in_data and in_valid of non-granted channels are ignored; they are never
//    accepted or dropped silently. A producer holds its data until it sees
//    ready.
//  - No arithmetic beyond the rr_ptr modulo-N wrap: rr_ptr+1 wraps N-1 -> 0
//    for non-power-of-2 N.
// STRUCTURE
//  - mux_pkg: ARB_FIXED=1'b0 and ARB_RR=1'b1 localparams, plus typedef
//    arb_mode_t.
//  - Sub-module rr_arbiter #(N): inputs req[N] and ptr; outputs grant_idx and
//    grant_vld. It is combinational; rr_ptr lives in stream_mux_arb.
//    Instantiate it only in the ARB_RR generate branch.
//  - Buffer: 2 entries {WIDTH+SEL_W}, 1-bit read pointer, 1-bit write pointer,
//    and a 2-bit count.
// TESTING
//  1. Fixed, N=4: sel=2, in_valid=4'b0100, data=32'hDEAD_BEEF, out_ready=1
//     -> next cycle out_valid=1, out_data=DEAD_BEEF, out_src=2. in_ready is
//     4'b0100 every cycle.
//  2. Backpressure: out_ready=0, stream A,B,C on ch1 -> A and B accepted,
//     in_ready=0 at count=2, C held. Raise out_ready -> out_data sequence
//     A,B,C, one per cycle, with no loss or duplication.
//  3. RR, N=4: all in_valid=1, out_ready=1 -> out_src sequence
//     0,1,2,3,0,1... After reset, first grant is ch0.
//  4. RR, N=3 (non-power-of-2): only ch2 and ch0 valid -> out_src alternates
//     2,0,2,0. rr_ptr wraps 2 -> 0, and index 3 never appears.
//  5. Reset mid-operation: buffer full (count=2), assert rst for 1 cycle ->
//     out_valid=0, out_data=0, and in_ready reflects empty buffer next cycle.
//     RR restarts at ch0.
//  6. Fixed, N=3, sel=3 (out of range) -> in_ready=0 on all channels and
//     out_valid stays 0.

Source files
------------

// File: rtl/mux_pkg.sv
// rtl/mux_pkg.sv - shared grant-mode constants for the stream multiplexer
package mux_pkg;

    typedef logic arb_mode_t;

    localparam arb_mode_t ARB_FIXED = 1'b0;
    localparam arb_mode_t ARB_RR    = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick, scanning from ptr+1 modulo N
module rr_arbiter #(
    parameter int N     = 4,
    parameter int SEL_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [SEL_W-1:0] grant_idx,
    output logic             grant_vld
);

    // Walk offsets from farthest to nearest so the channel right after ptr wins.
    always_comb begin
        int j;
        j         = 0;
        grant_idx = '0;
        grant_vld = 1'b0;
        for (int k = N; k >= 1; k--) begin
            j = int'(ptr) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (req[j]) begin
                grant_idx = SEL_W'(j);
                grant_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_mux_arb.sv
// rtl/stream_mux_arb.sv - N-channel stream mux with fixed or round-robin grant
// and a 2-entry registered output buffer.
module stream_mux_arb
    import mux_pkg::*;
#(
    parameter int        WIDTH    = 32,
    parameter int        N        = 4,
    parameter int        SEL_W    = $clog2(N),
    parameter arb_mode_t ARB_MODE = ARB_FIXED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     in_valid,
    output logic [N-1:0]     in_ready,
    input  logic [WIDTH-1:0] in_data [N],
    input  logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SEL_W-1:0] out_src
);

    localparam int EW = WIDTH + SEL_W;

    logic [EW-1:0]    mem_q [2];
    logic             rd_ptr_q;
    logic             wr_ptr_q;
    logic [1:0]       count_q;
    logic [1:0]       count_d;
    logic             space;
    logic             push;
    logic             pop;
    logic [SEL_W-1:0] grant_idx;
    logic             grant_vld;

    if (ARB_MODE == ARB_RR) begin : g_rr
        logic [SEL_W-1:0] rr_ptr_q;

        rr_arbiter #(.N(N), .SEL_W(SEL_W)) u_arb (
            .req       (in_valid),
            .ptr       (rr_ptr_q),
            .grant_idx (grant_idx),
            .grant_vld (grant_vld)
        );

        // Reset to N-1 so the first scan starts at channel 0.
        always_ff @(posedge clk) begin
            if (rst) begin
                rr_ptr_q <= SEL_W'(N - 1);
            end else if (push) begin
                rr_ptr_q <= grant_idx;
            end
        end
    end else begin : g_fixed
        assign grant_idx = sel;
        assign grant_vld = ({1'b0, sel} < (SEL_W + 1)'(N));
    end

    assign space = ~count_q[1];

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = space && grant_vld && (grant_idx == SEL_W'(i));
        end
    end

    assign push      = |(in_valid & in_ready);
    assign out_valid = (count_q != 2'd0);
    assign pop       = out_valid && out_ready;
    assign out_data  = mem_q[rd_ptr_q][EW-1:SEL_W];
    assign out_src   = mem_q[rd_ptr_q][SEL_W-1:0];

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= {in_data[grant_idx], grant_idx};
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_d;
        end
    end

endmodule

// File: tb/tb_stream_mux_arb.sv
// tb/tb_stream_mux_arb.sv - directed self-checking bench for stream_mux_arb
module tb_stream_mux_arb;
    import mux_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Fixed N=4
    logic [3:0]  f4_iv, f4_ir;
    logic [31:0] f4_id [4];
    logic [1:0]  f4_sel, f4_os;
    logic        f4_ov, f4_or;
    logic [31:0] f4_od;
    // Round-robin N=4
    logic [3:0]  r4_iv, r4_ir;
    logic [31:0] r4_id [4];
    logic [1:0]  r4_sel, r4_os;
    logic        r4_ov, r4_or;
    logic [31:0] r4_od;
    // Round-robin N=3
    logic [2:0]  r3_iv, r3_ir;
    logic [31:0] r3_id [3];
    logic [1:0]  r3_sel, r3_os;
    logic        r3_ov, r3_or;
    logic [31:0] r3_od;
    // Fixed N=3
    logic [2:0]  x3_iv, x3_ir;
    logic [31:0] x3_id [3];
    logic [1:0]  x3_sel, x3_os;
    logic        x3_ov, x3_or;
    logic [31:0] x3_od;

    stream_mux_arb #(.WIDTH(32), .N(4), .ARB_MODE(ARB_FIXED)) u_f4 (
        .clk(clk), .rst(rst), .in_valid(f4_iv), .in_ready(f4_ir), .in_data(f4_id),
        .sel(f4_sel), .out_valid(f4_ov), .out_ready(f4_or), .out_data(f4_od), .out_src(f4_os));
    stream_mux_arb #(.WIDTH(32), .N(4), .ARB_MODE(ARB_RR)) u_r4 (
        .clk(clk), .rst(rst), .in_valid(r4_iv), .in_ready(r4_ir), .in_data(r4_id),
        .sel(r4_sel), .out_valid(r4_ov), .out_ready(r4_or), .out_data(r4_od), .out_src(r4_os));
    stream_mux_arb #(.WIDTH(32), .N(3), .ARB_MODE(ARB_RR)) u_r3 (
        .clk(clk), .rst(rst), .in_valid(r3_iv), .in_ready(r3_ir), .in_data(r3_id),
        .sel(r3_sel), .out_valid(r3_ov), .out_ready(r3_or), .out_data(r3_od), .out_src(r3_os));
    stream_mux_arb #(.WIDTH(32), .N(3), .ARB_MODE(ARB_FIXED)) u_x3 (
        .clk(clk), .rst(rst), .in_valid(x3_iv), .in_ready(x3_ir), .in_data(x3_id),
        .sel(x3_sel), .out_valid(x3_ov), .out_ready(x3_or), .out_data(x3_od), .out_src(x3_os));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        f4_iv = '0; f4_sel = '0; f4_or = 1'b0;
        r4_iv = '0; r4_sel = '0; r4_or = 1'b0;
        r3_iv = '0; r3_sel = '0; r3_or = 1'b0;
        x3_iv = '0; x3_sel = '0; x3_or = 1'b0;
        for (int i = 0; i < 4; i++) begin
            f4_id[i] = '0;
            r4_id[i] = '0;
        end
        for (int i = 0; i < 3; i++) begin
            r3_id[i] = '0;
            x3_id[i] = '0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        do_reset();
        checks++; if (f4_ov !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", f4_ov); end
        checks++; if (f4_od !== 32'h0) begin errors++; $display("FAIL reset_out_data: got %h expected 00000000", f4_od); end
        checks++; if (f4_os !== 2'd0) begin errors++; $display("FAIL reset_out_src: got %0d expected 0", f4_os); end
        checks++; if (f4_ir !== 4'b0001) begin errors++; $display("FAIL reset_fixed_ready: got %b expected 0001", f4_ir); end
        checks++; if (r4_ir !== 4'b0000) begin errors++; $display("FAIL reset_rr_ready_idle: got %b expected 0000", r4_ir); end
    endtask

    task automatic test_fixed();
        idle_inputs();
        do_reset();
        f4_sel = 2'd2; f4_or = 1'b1;
        #1;
        checks++; if (f4_ir !== 4'b0100) begin errors++; $display("FAIL fixed_ready_novalid: got %b expected 0100", f4_ir); end
        f4_iv = 4'b0100; f4_id[2] = 32'hDEAD_BEEF;
        #1;
        checks++; if (f4_ir !== 4'b0100) begin errors++; $display("FAIL fixed_ready_pre: got %b expected 0100", f4_ir); end
        step();
        f4_iv = 4'b0000;
        #1;
        checks++; if (f4_ov !== 1'b1) begin errors++; $display("FAIL fixed_out_valid: got %b expected 1", f4_ov); end
        checks++; if (f4_od !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fixed_out_data: got %h expected deadbeef", f4_od); end
        checks++; if (f4_os !== 2'd2) begin errors++; $display("FAIL fixed_out_src: got %0d expected 2", f4_os); end
        checks++; if (f4_ir !== 4'b0100) begin errors++; $display("FAIL fixed_ready_post: got %b expected 0100", f4_ir); end
        step();
        checks++; if (f4_ov !== 1'b0) begin errors++; $display("FAIL fixed_drained: got %b expected 0", f4_ov); end
        checks++; if (f4_ir !== 4'b0100) begin errors++; $display("FAIL fixed_ready_drained: got %b expected 0100", f4_ir); end
    endtask

    task automatic test_backpressure();
        idle_inputs();
        do_reset();
        f4_sel = 2'd1; f4_or = 1'b0;
        f4_iv = 4'b0010; f4_id[1] = 32'hAAAA_0001;
        step();
        f4_id[1] = 32'hBBBB_0002;
        step();
        f4_id[1] = 32'hCCCC_0003;
        #1;
        checks++; if (f4_ir !== 4'b0000) begin errors++; $display("FAIL bp_full_ready: got %b expected 0000", f4_ir); end
        checks++; if (f4_od !== 32'hAAAA_0001) begin errors++; $display("FAIL bp_head_a: got %h expected aaaa0001", f4_od); end
        checks++; if (f4_os !== 2'd1) begin errors++; $display("FAIL bp_head_src: got %0d expected 1", f4_os); end
        step();
        checks++; if (f4_od !== 32'hAAAA_0001 || f4_ov !== 1'b1) begin errors++; $display("FAIL bp_stall_stable: got %h/%b expected aaaa0001/1", f4_od, f4_ov); end
        checks++; if (f4_ir !== 4'b0000) begin errors++; $display("FAIL bp_stall_ready: got %b expected 0000", f4_ir); end
        f4_or = 1'b1;
        step();
        checks++; if (f4_od !== 32'hBBBB_0002 || f4_ov !== 1'b1) begin errors++; $display("FAIL bp_second_b: got %h/%b expected bbbb0002/1", f4_od, f4_ov); end
        checks++; if (f4_ir !== 4'b0010) begin errors++; $display("FAIL bp_ready_reopen: got %b expected 0010", f4_ir); end
        step();
        f4_iv = 4'b0000;
        #1;
        checks++; if (f4_od !== 32'hCCCC_0003 || f4_ov !== 1'b1) begin errors++; $display("FAIL bp_third_c: got %h/%b expected cccc0003/1", f4_od, f4_ov); end
        step();
        checks++; if (f4_ov !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got %b expected 0", f4_ov); end
    endtask

    task automatic test_rr4();
        idle_inputs();
        do_reset();
        r4_iv = 4'b1111; r4_or = 1'b1;
        for (int i = 0; i < 4; i++) r4_id[i] = 32'h100 + 32'(i);
        for (int k = 0; k < 6; k++) begin
            step();
            checks++;
            if (r4_ov !== 1'b1 || r4_os !== 2'(k % 4) || r4_od !== 32'h100 + 32'(k % 4)) begin
                errors++;
                $display("FAIL rr4_seq[%0d]: got v=%b src=%0d data=%h expected v=1 src=%0d data=%h",
                         k, r4_ov, r4_os, r4_od, k % 4, 32'h100 + 32'(k % 4));
            end
        end
    endtask

    task automatic test_rr3_wrap();
        idle_inputs();
        do_reset();
        r3_or = 1'b1;
        for (int i = 0; i < 3; i++) r3_id[i] = 32'h300 + 32'(i);
        r3_iv = 3'b010;
        step();
        checks++; if (r3_os !== 2'd1 || r3_ov !== 1'b1) begin errors++; $display("FAIL rr3_prime: got src=%0d v=%b expected src=1 v=1", r3_os, r3_ov); end
        r3_iv = 3'b101;
        for (int k = 0; k < 6; k++) begin
            logic [1:0] exp_src;
            exp_src = (k % 2 == 0) ? 2'd2 : 2'd0;
            step();
            checks++;
            if (r3_os !== exp_src || r3_od !== 32'h300 + 32'(exp_src)) begin
                errors++;
                $display("FAIL rr3_seq[%0d]: got src=%0d data=%h expected src=%0d data=%h",
                         k, r3_os, r3_od, exp_src, 32'h300 + 32'(exp_src));
            end
        end
    endtask

    task automatic test_reset_mid();
        idle_inputs();
        do_reset();
        r4_iv = 4'b1111; r4_or = 1'b0;
        for (int i = 0; i < 4; i++) r4_id[i] = 32'h400 + 32'(i);
        step();
        step();
        checks++; if (r4_ir !== 4'b0000 || r4_ov !== 1'b1) begin errors++; $display("FAIL mid_full: got ready=%b v=%b expected 0000/1", r4_ir, r4_ov); end
        do_reset();
        checks++; if (r4_ov !== 1'b0 || r4_od !== 32'h0) begin errors++; $display("FAIL mid_cleared: got v=%b data=%h expected 0/00000000", r4_ov, r4_od); end
        checks++; if (r4_ir !== 4'b0001) begin errors++; $display("FAIL mid_ready_empty: got %b expected 0001", r4_ir); end
        r4_or = 1'b1;
        step();
        checks++; if (r4_os !== 2'd0 || r4_od !== 32'h400) begin errors++; $display("FAIL mid_rr_restart: got src=%0d data=%h expected 0/00000400", r4_os, r4_od); end
    endtask

    task automatic test_fixed_oor();
        idle_inputs();
        do_reset();
        x3_sel = 2'd3; x3_iv = 3'b111; x3_or = 1'b1;
        for (int i = 0; i < 3; i++) x3_id[i] = 32'h500 + 32'(i);
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++; if (x3_ir !== 3'b000) begin errors++; $display("FAIL oor_ready[%0d]: got %b expected 000", k, x3_ir); end
            step();
            checks++; if (x3_ov !== 1'b0) begin errors++; $display("FAIL oor_out_valid[%0d]: got %b expected 0", k, x3_ov); end
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_fixed();
        test_backpressure();
        test_rr4();
        test_rr3_wrap();
        test_reset_mid();
        test_fixed_oor();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
